// File: rtl/spi_burst_slave_if.sv
// spi_burst_slave_if: SPI pins and register-bus signals of the burst slave
interface spi_burst_slave_if #(parameter int DW = 16, parameter int AW = 16);
  logic spi_clk, spi_csn, spi_mosi, spi_miso, spi_miso_oe;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic wen, ren, rvalid, rd_underrun, frame_done;
  modport slave (
    input spi_clk, spi_csn, spi_mosi, rdata, rvalid,
    output spi_miso, spi_miso_oe, addr, wdata, wen, ren, rd_underrun, frame_done
  );
  modport master (
    output spi_clk, spi_csn, spi_mosi, rdata, rvalid,
    input spi_miso, spi_miso_oe, addr, wdata, wen, ren, rd_underrun, frame_done
  );
endinterface

// File: rtl/spi_burst_slave.sv
// spi_burst_slave: oversampled SPI mode-0 slave turning each CSN frame into auto-incrementing bus bursts
module spi_burst_slave #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int DUMMY = 8,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst,
  spi_burst_slave_if.slave bus
);
  localparam int SW = (AW + 2 > DW) ? AW + 2 : DW;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_DUMMY, S_RDATA, S_NOP} state_t;
  state_t state, state_n;
  logic [2:0] sclk_s, csn_s;
  logic [1:0] mosi_s;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sh;
  logic [DW-1:0] tx, rbuf;
  logic [AW+1:0] hdr;
  logic rbuf_v, pend, word_done, hdr_rd, pf_inc, pf_ren;
  logic rise, fall, cs_start, cs_end, mosi, hdr_last, word_last, load;
  assign cs_start = ~csn_s[1] & csn_s[2];
  assign cs_end = csn_s[1] & ~csn_s[2];
  assign rise = sclk_s[1] & ~sclk_s[2] & ~cs_end;
  assign fall = ~sclk_s[1] & sclk_s[2] & ~cs_end;
  assign mosi = mosi_s[1];
  assign hdr = {sh[AW:0], mosi};
  assign hdr_last = rise && state == S_HDR && cnt == CW'(AW + 1);
  assign word_last = rise && state == S_WDATA && cnt == CW'(DW - 1);
  assign load = fall && ((state == S_DUMMY && cnt == CW'(DUMMY)) || (state == S_RDATA && cnt == CW'(DW - 1)));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = cs_end ? S_IDLE :
              (state == S_IDLE && cs_start) ? S_HDR :
              hdr_last ? (hdr[AW+1:AW] == 2'b10 ? S_WDATA : hdr[AW+1:AW] == 2'b01 ? S_DUMMY : S_NOP) :
              (state == S_DUMMY && load) ? S_RDATA : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_s <= '0;
      csn_s <= '1;
      mosi_s <= '0;
      cnt <= '0;
      sh <= '0;
      tx <= '0;
      rbuf <= '0;
      rbuf_v <= 1'b0;
      pend <= 1'b0;
      word_done <= 1'b0;
      hdr_rd <= 1'b0;
      pf_inc <= 1'b0;
      pf_ren <= 1'b0;
      bus.spi_miso <= 1'b0;
      bus.spi_miso_oe <= 1'b0;
      bus.addr <= '0;
      bus.wdata <= '0;
      bus.wen <= 1'b0;
      bus.ren <= 1'b0;
      bus.rd_underrun <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], bus.spi_clk};
      csn_s <= {csn_s[1:0], bus.spi_csn};
      mosi_s <= {mosi_s[0], bus.spi_mosi};
      bus.wen <= word_done;
      bus.ren <= hdr_rd | pf_ren;
      bus.rd_underrun <= load & ~rbuf_v;
      bus.frame_done <= cs_end & (state != S_IDLE);
      bus.spi_miso <= (state == S_RDATA) & ~cs_end & tx[DW-1];
      bus.spi_miso_oe <= state_n == S_DUMMY || state_n == S_RDATA;
      word_done <= word_last;
      hdr_rd <= hdr_last && hdr[AW+1:AW] == 2'b01;
      pf_inc <= load & rbuf_v;
      pf_ren <= pf_inc;
      if (word_done) bus.wdata <= sh[DW-1:0];
      if (bus.wen || pf_inc) bus.addr <= bus.addr + 1'b1;
      if (hdr_last) bus.addr <= hdr[AW-1:0];
      if (hdr_rd || pf_ren) pend <= 1'b1;
      if (state == S_IDLE && cs_start) cnt <= '0;
      if (hdr_last || word_last) cnt <= '0;
      else if (rise && (state == S_HDR || state == S_WDATA || state == S_DUMMY)) cnt <= cnt + 1'b1;
      if (rise && (state == S_HDR || state == S_WDATA)) sh <= {sh[SW-2:0], mosi};
      if (load) begin
        tx <= rbuf_v ? rbuf : '0;
        rbuf_v <= 1'b0;
        cnt <= '0;
      end else if (fall && state == S_RDATA) begin
        tx <= tx << 1;
        cnt <= cnt + 1'b1;
      end
      if (bus.rvalid && pend) begin
        rbuf <= bus.rdata;
        rbuf_v <= 1'b1;
        pend <= 1'b0;
      end
      if (cs_end) begin
        cnt <= '0;
        pend <= 1'b0;
        rbuf_v <= 1'b0;
        word_done <= 1'b0;
        hdr_rd <= 1'b0;
        pf_inc <= 1'b0;
        pf_ren <= 1'b0;
        bus.ren <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_burst_slave.sv
// tb_spi_burst_slave: table-driven frame vectors plus abort and reset sequences for spi_burst_slave
module tb_spi_burst_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_burst_slave_if #(.DW(16), .AW(16)) b ();
  spi_burst_slave #(.DW(16), .AW(16), .DUMMY(8), .CW(8)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct {
    logic [1:0] cmd;
    logic [15:0] a;
    int n;
    int hp;
    bit mem;
    logic [15:0] d0, d1, d2;
    int e_wen, e_ren, e_und;
    logic [15:0] r0, r1;
    bit e_oe, e_ms;
  } vec_t;
  int n_cmp = 0;
  int n_bad = 0;
  int hp = 4;
  bit mem_en = 1'b0;
  int mem_cnt = 0;
  logic [15:0] mem_a;
  logic [15:0] wa[$], wd[$], ra[$];
  int und_n, fd_n, both_n;
  bit oe_seen, miso_seen;
  always @(negedge clk) begin
    b.rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0 && mem_en) begin
        b.rvalid = 1'b1;
        b.rdata = mem_a ^ 16'hFFFF;
      end
    end
    if (b.ren === 1'b1) begin
      mem_a = b.addr;
      mem_cnt = 2;
    end
  end
  always @(negedge clk) begin
    if (b.wen === 1'b1) begin
      wa.push_back(b.addr);
      wd.push_back(b.wdata);
    end
    if (b.ren === 1'b1) ra.push_back(b.addr);
    if (b.rd_underrun === 1'b1) und_n++;
    if (b.frame_done === 1'b1) fd_n++;
    if (b.wen === 1'b1 && b.ren === 1'b1) both_n++;
    if (b.spi_miso_oe === 1'b1) oe_seen = 1'b1;
    if (b.spi_miso === 1'b1) miso_seen = 1'b1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clear_mon();
    wa.delete();
    wd.delete();
    ra.delete();
    und_n = 0;
    fd_n = 0;
    oe_seen = 1'b0;
    miso_seen = 1'b0;
  endtask
  task automatic sbit(input logic m, output logic s);
    b.spi_clk = 1'b0;
    b.spi_mosi = m;
    repeat (hp) @(negedge clk);
    s = b.spi_miso;
    b.spi_clk = 1'b1;
    repeat (hp) @(negedge clk);
  endtask
  task automatic cs_lo();
    b.spi_csn = 1'b0;
    repeat (hp) @(negedge clk);
  endtask
  task automatic cs_hi();
    b.spi_csn = 1'b1;
    repeat (hp) @(negedge clk);
    b.spi_clk = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic header(input logic [1:0] c, input logic [15:0] a);
    logic [17:0] h;
    logic s;
    h = {c, a};
    for (int i = 17; i >= 0; i--) sbit(h[i], s);
  endtask
  task automatic dummies();
    logic s;
    for (int i = 0; i < 8; i++) sbit(1'b0, s);
  endtask
  task automatic word(input logic [15:0] d, input int nb, output logic [15:0] r);
    logic s;
    r = '0;
    for (int i = 15; i > 15 - nb; i--) begin
      sbit(d[i], s);
      r[i] = s;
    end
  endtask
  initial begin
    vec_t v[5];
    logic [15:0] r, dsel;
    string t;
    v[0] = '{2'b10, 16'h0010, 3, 4, 1'b0, 16'hA5A5, 16'h1234, 16'h00FF, 3, 0, 0, 16'h0, 16'h0, 1'b0, 1'b0};
    v[1] = '{2'b01, 16'h0200, 2, 6, 1'b1, 16'h0, 16'h0, 16'h0, 0, 3, 0, 16'hFDFF, 16'hFDFE, 1'b1, 1'b1};
    v[2] = '{2'b01, 16'h0300, 2, 6, 1'b0, 16'h0, 16'h0, 16'h0, 0, 1, 2, 16'h0, 16'h0, 1'b1, 1'b0};
    v[3] = '{2'b10, 16'hFFFF, 2, 4, 1'b0, 16'h1111, 16'h2222, 16'h0, 2, 0, 0, 16'h0, 16'h0, 1'b0, 1'b0};
    v[4] = '{2'b11, 16'h1234, 1, 4, 1'b0, 16'hBEEF, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1'b0, 1'b0};
    b.spi_clk = 1'b0;
    b.spi_csn = 1'b1;
    b.spi_mosi = 1'b0;
    both_n = 0;
    repeat (4) @(negedge clk);
    chk("reset outputs", {b.spi_miso, b.spi_miso_oe, b.addr, b.wdata, b.wen, b.ren, b.rd_underrun, b.frame_done}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      hp = v[k].hp;
      mem_en = v[k].mem;
      clear_mon();
      cs_lo();
      header(v[k].cmd, v[k].a);
      if (v[k].cmd == 2'b01) dummies();
      for (int i = 0; i < v[k].n; i++) begin
        dsel = i == 0 ? v[k].d0 : i == 1 ? v[k].d1 : v[k].d2;
        word(dsel, 16, r);
        t = $sformatf("v%0d miso word%0d", k, i);
        if (v[k].cmd == 2'b01) chk(t, r, i == 0 ? v[k].r0 : v[k].r1);
      end
      cs_hi();
      chk($sformatf("v%0d wen count", k), wa.size(), v[k].e_wen);
      chk($sformatf("v%0d ren count", k), ra.size(), v[k].e_ren);
      chk($sformatf("v%0d underrun count", k), und_n, v[k].e_und);
      chk($sformatf("v%0d frame_done count", k), fd_n, 1);
      chk($sformatf("v%0d oe seen", k), oe_seen, v[k].e_oe);
      chk($sformatf("v%0d miso seen", k), miso_seen, v[k].e_ms);
      for (int i = 0; i < v[k].e_wen; i++) begin
        dsel = i == 0 ? v[k].d0 : i == 1 ? v[k].d1 : v[k].d2;
        chk($sformatf("v%0d wen addr%0d", k, i), i < wa.size() ? wa[i] : 16'hxxxx, 16'(v[k].a + 16'(i)));
        chk($sformatf("v%0d wen data%0d", k, i), i < wd.size() ? wd[i] : 16'hxxxx, dsel);
      end
      for (int i = 0; i < v[k].e_ren; i++)
        chk($sformatf("v%0d ren addr%0d", k, i), i < ra.size() ? ra[i] : 16'hxxxx, 16'(v[k].a + 16'(i)));
    end
    hp = 4;
    mem_en = 1'b0;
    clear_mon();
    cs_lo();
    header(2'b10, 16'h0040);
    word(16'hCAFE, 16, r);
    word(16'h1357, 7, r);
    cs_hi();
    chk("abort wen count", wa.size(), 1);
    chk("abort wen addr", wa.size() > 0 ? wa[0] : 16'hxxxx, 16'h0040);
    chk("abort wen data", wd.size() > 0 ? wd[0] : 16'hxxxx, 16'hCAFE);
    chk("abort frame_done", fd_n, 1);
    clear_mon();
    cs_lo();
    header(2'b10, 16'h0000);
    word(16'h5A5A, 16, r);
    cs_hi();
    chk("recover wen count", wa.size(), 1);
    chk("recover wen addr", wa.size() > 0 ? wa[0] : 16'hxxxx, 16'h0000);
    chk("recover wen data", wd.size() > 0 ? wd[0] : 16'hxxxx, 16'h5A5A);
    hp = 6;
    mem_en = 1'b1;
    clear_mon();
    cs_lo();
    header(2'b01, 16'h0500);
    dummies();
    word(16'h0, 5, r);
    rst = 1'b1;
    #1;
    chk("mid-read reset outputs", {b.spi_miso, b.spi_miso_oe, b.addr, b.wdata, b.wen, b.ren, b.rd_underrun, b.frame_done}, 32'h0);
    b.spi_csn = 1'b1;
    b.spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    clear_mon();
    cs_lo();
    header(2'b01, 16'h0500);
    dummies();
    word(16'h0, 16, r);
    cs_hi();
    chk("post-reset read word", r, 16'hFAFF);
    chk("post-reset ren addr", ra.size() > 0 ? ra[0] : 16'hxxxx, 16'h0500);
    chk("post-reset underrun", und_n, 0);
    chk("wen/ren overlap", both_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_burst_slave.md
# spi_burst_slave

Single-clock, oversampling SPI mode-0 slave that turns each chip-select frame into a burst of word-wide register-bus accesses with auto-incrementing address. It is the parametrised successor to the per-word SPI slave on the PE host link: SPI pins are synchronised into `clk`, so there is no second clock domain. Burst length is set by how long `spi_csn` stays low. A read prefetch buffer and a configurable dummy phase give the PE time to return read data.

## Interface
- `DW`, 16: data word width, ≥ 2.
- `AW`, 16: address width; the header is 2 + `AW` bits.
- `DUMMY`, 8: number of dummy SPI bits between the header and the first read word, ≥ 1.
- `CW`, 8: internal bit-counter width; must satisfy 2^`CW` > max(`AW`+2, `DW`, `DUMMY`).

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `spi_clk`  in  1: SPI SCLK, asynchronous to `clk`.
- `spi_csn`  in  1: active-low frame select, asynchronous.
- `spi_mosi`  in  1: host → slave data, MSB first.
- `spi_miso`  out  1: slave → host data, registered.
- `spi_miso_oe`  out  1: high only while a read frame is in the dummy or data phase.
- `addr`  out  `AW`: bus address, valid whenever `wen` or `ren` is high.
- `wdata`  out  `DW`: write data, valid with `wen`.
- `wen`  out  1: one-cycle write strobe.
- `ren`  out  1: one-cycle read request.
- `rdata`  in  `DW`: read data.
- `rvalid`  in  1: `rdata` is valid; only meaningful while a request is outstanding.
- `rd_underrun`  out  1: one-cycle pulse when a read word is sent without data.
- `frame_done`  out  1: one-cycle pulse on every deassertion of `spi_csn` that ends a non-idle frame.

## Operation
- **Synchronisers and edges.** `spi_clk`, `spi_csn` and `spi_mosi` each pass through a 2-flop synchroniser. A third flop on `spi_clk` and `spi_csn` provides edge detection.
  - `rise`: synchronised SCLK 0→1. Sample MOSI on this event.
  - `fall`: synchronised SCLK 1→0. Update MISO on this event.
  - `cs_start`: synchronised CSN 1→0.
  - `cs_end`: synchronised CSN 0→1.
- **Frame format.** `cmd[1:0]`, then `addr[AW-1:0]`, then data words, all MSB first.
  - `cmd` 2'b10 = write, 2'b01 = read, anything else = no-op.
- **FSM states.** IDLE, HDR, WDATA, DUMMY, RDATA, NOP.
  - IDLE → HDR on `cs_start`; clear the bit counter.
  - HDR shifts `AW`+2 bits. On the last `rise`, load `addr`, then branch:
    - cmd 10 → WDATA.
    - cmd 01 → DUMMY, and pulse `ren` with the loaded address on the next cycle.
    - otherwise → NOP.
  - WDATA, after every `DW`-th `rise`:
    - next cycle: `wdata` = assembled word, `wen` = 1 for one cycle;
    - cycle after `wen`: `addr` += 1, modulo 2^`AW`.
  - DUMMY counts `DUMMY` rises; MOSI is ignored. On the `fall` after the last dummy `rise`, load the TX shifter from the read buffer and go to RDATA.
  - RDATA: each `fall` shifts the TX shifter left, and `spi_miso` = shifter MSB.
    - On the `fall` that follows bit 0 of a word, load the next word.
    - Each load that consumes the buffer issues the prefetch: `addr` += 1, then `ren` one cycle later.
  - NOP: `spi_miso` = 0, `spi_miso_oe` = 0, no bus activity.
- **Read buffer.**
  - One-entry buffer; at most one request outstanding.
  - `rvalid` sets buffer-valid and captures `rdata`. `rvalid` with no request outstanding is ignored.
  - A load with the buffer not valid sends all zeros for that word and pulses `rd_underrun`. The outstanding request still completes into the buffer, and no new `ren` is issued for that load.
- **Frame end.** `cs_end` in any state:
  - go to IDLE, pulse `frame_done`;
  - drop a partially received write word, with no `wen`;
  - cancel the outstanding request flag; a late `rvalid` is ignored;
  - force `spi_miso` = 0 and `spi_miso_oe` = 0.
- **`cs_end` vs `rise` in the same cycle.** `cs_end` wins; the sample is discarded.

## Timing
- **Reset.** Every output is 0: `spi_miso`, `spi_miso_oe`, `addr`, `wdata`, `wen`, `ren`, `rd_underrun`, `frame_done`. FSM = IDLE, buffer invalid. Reset mid-frame aborts the frame.
- **SCLK constraints.** Each SCLK phase must last ≥ 4 `clk` cycles. CSN setup and hold to SCLK must be ≥ 4 `clk` cycles.
- **Latencies.**
  - Pin edge to `rise`/`fall` detection: 3 `clk` cycles.
  - Pin rise of the last bit of a word to `wen`: 4 cycles.
  - Pin rise of the last header bit to `ren`: 4 cycles.
  - Pin fall to new `spi_miso`: 4 cycles.
- **Read-latency requirement.** `rvalid` must arrive no later than `DUMMY` SCLK periods after `ren` for the first word, and `DW` periods after `ren` for each later word. Otherwise `rd_underrun` fires.
- **Bus handshakes.** `wen` and `ren` are never high in the same cycle. The bus is always ready; there is no stall input.

## Test plan
- **Write burst.** cmd 10, addr 0x0010, words 0xA5A5, 0x1234, 0x00FF, with SCLK = `clk`/8 → three `wen` pulses: (0x0010, 0xA5A5), (0x0011, 0x1234), (0x0012, 0x00FF); then `frame_done`.
- **Read burst.** cmd 01, addr 0x0200, memory model returns addr ^ 0xFFFF after 2 cycles, 2 words → MISO carries 0xFDFF then 0xFDFE; `ren` fires at 0x0200 and 0x0201, plus the prefetch at 0x0202; `rd_underrun` never fires.
- **Underrun.** Read frame with `rvalid` held low → 16 zero bits on MISO, `rd_underrun` = 1 pulse per word.
- **Abort and recovery.** CSN rises after 7 bits of the second write word → exactly 1 `wen`; FSM returns to IDLE. A following write frame to 0x0000 writes correctly.
- **Wrap and no-op.** Write burst at 0xFFFF with 2 words → `wen` at 0xFFFF, then at 0x0000. Then a frame with cmd 11 → no `wen`/`ren`, MISO = 0, `spi_miso_oe` = 0.
- **Reset mid-read.** Assert `rst` during RDATA → all outputs 0 at once. After release, a normal read frame returns correct data.
